// File: rtl/bus_arbiter_if.sv
// Request/grant handshake between two bus masters and the arbiter.
// master: the requesting side; slave: the arbiter side.
interface bus_arbiter_if;
    logic m1_request;
    logic m2_request;
    logic m1_done;
    logic m2_done;
    logic m1_grant;
    logic m2_grant;
    logic m1_busy;
    logic m2_busy;
    logic bus_sel;
    logic timeout;
    logic timeout_id;

    modport master (
        output m1_request, m2_request, m1_done, m2_done,
        input  m1_grant, m2_grant, m1_busy, m2_busy, bus_sel, timeout, timeout_id
    );

    modport slave (
        input  m1_request, m2_request, m1_done, m2_done,
        output m1_grant, m2_grant, m1_busy, m2_busy, bus_sel, timeout, timeout_id
    );
endinterface

// File: rtl/bus_arbiter.sv
// Two-master round-robin bus arbiter with turnaround cycle and grant-hold timeout.
// Every output is a flop loaded from the next-state decode.
module bus_arbiter #(
    parameter int unsigned TIMEOUT = 200
) (
    input  logic          clk,
    input  logic          reset,
    bus_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, GRANT_M1, GRANT_M2, TURN} state_t;

    state_t      state, state_nxt;
    logic        last_grant, last_grant_nxt;
    logic [7:0]  hold_cnt;
    logic        at_limit;
    logic        forced;
    logic        granting;

    assign at_limit = (hold_cnt == 8'(TIMEOUT - 1));
    assign granting = (state_nxt == GRANT_M1) || (state_nxt == GRANT_M2);

    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        forced         = 1'b0;
        case (state)
            IDLE: begin
                // last_grant == 1 means m2 went last, so m1 wins a tie
                if (bus.m1_request && (!bus.m2_request || last_grant))
                    state_nxt = GRANT_M1;
                else if (bus.m2_request)
                    state_nxt = GRANT_M2;
            end
            GRANT_M1: begin
                forced = at_limit && !bus.m1_done;
                if (bus.m1_done || !bus.m1_request || forced) begin
                    state_nxt      = TURN;
                    last_grant_nxt = 1'b0;
                end
            end
            GRANT_M2: begin
                forced = at_limit && !bus.m2_done;
                if (bus.m2_done || !bus.m2_request || forced) begin
                    state_nxt      = TURN;
                    last_grant_nxt = 1'b1;
                end
            end
            TURN:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            last_grant     <= 1'b1;
            hold_cnt       <= '0;
            bus.m1_grant   <= 1'b0;
            bus.m2_grant   <= 1'b0;
            bus.m1_busy    <= 1'b0;
            bus.m2_busy    <= 1'b0;
            bus.bus_sel    <= 1'b0;
            bus.timeout    <= 1'b0;
            bus.timeout_id <= 1'b0;
        end else begin
            state        <= state_nxt;
            last_grant   <= last_grant_nxt;
            bus.m1_grant <= (state_nxt == GRANT_M1);
            bus.m2_grant <= (state_nxt == GRANT_M2);
            bus.m1_busy  <= (state_nxt == GRANT_M2);
            bus.m2_busy  <= (state_nxt == GRANT_M1);
            bus.timeout  <= forced;
            if (forced)
                bus.timeout_id <= (state == GRANT_M2);
            if (granting) begin
                if (state_nxt != state) begin
                    hold_cnt    <= '0;
                    bus.bus_sel <= (state_nxt == GRANT_M2);
                end else begin
                    hold_cnt <= hold_cnt + 8'd1;
                end
            end else begin
                hold_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: default-TIMEOUT and TIMEOUT=4 instances,
// expected output vectors queued with each stimulus step and checked after the edge.
module tb_bus_arbiter;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    bus_arbiter_if ifa ();
    bus_arbiter_if ifb ();

    bus_arbiter dut_a (.clk(clk), .reset(reset), .bus(ifa));
    bus_arbiter #(.TIMEOUT(4)) dut_b (.clk(clk), .reset(reset), .bus(ifb));

    // {m1_grant, m2_grant, m1_busy, m2_busy, bus_sel, timeout, timeout_id}
    logic [6:0] vec_a, vec_b;
    assign vec_a = {ifa.m1_grant, ifa.m2_grant, ifa.m1_busy, ifa.m2_busy,
                    ifa.bus_sel, ifa.timeout, ifa.timeout_id};
    assign vec_b = {ifb.m1_grant, ifb.m2_grant, ifb.m1_busy, ifb.m2_busy,
                    ifb.bus_sel, ifb.timeout, ifb.timeout_id};

    logic [6:0] exp_q [$];

    localparam logic [6:0] G1 = 7'b1001000;
    localparam logic [6:0] G2 = 7'b0110100;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Queue the expectation for the coming edge, then compare once it has passed.
    task automatic step(input string tag, input bit sel_b, input logic [6:0] exp);
        logic [6:0] e;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk(tag, sel_b ? vec_b : vec_a, e);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b0;
        #2;
        chk(tag, vec_a, 7'b0000000);
        chk(tag, vec_b, 7'b0000000);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    always @(negedge clk) begin
        if (reset) begin
            checks++;
            assert (!(ifa.m1_grant && ifa.m2_grant) && !(ifb.m1_grant && ifb.m2_grant)) else begin
                errors++;
                $error("FAIL mutex observed=%b/%b expected=no double grant", vec_a[6:5], vec_b[6:5]);
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        {ifa.m1_request, ifa.m2_request, ifa.m1_done, ifa.m2_done} = '0;
        {ifb.m1_request, ifb.m2_request, ifb.m1_done, ifb.m2_done} = '0;
        #12;
        chk("reset_a", vec_a, 7'b0000000);
        chk("reset_b", vec_b, 7'b0000000);
        @(posedge clk);
        #1;
        reset = 1'b1;
        step("idle_a", 0, 7'b0000000);

        // single master 1 transaction
        ifa.m1_request = 1'b1;
        step("m1_grant", 0, G1);
        step("m1_hold1", 0, G1);
        step("m1_hold2", 0, G1);
        step("m1_hold3", 0, G1);
        ifa.m1_done = 1'b1;
        step("m1_turn", 0, 7'b0000000);
        ifa.m1_done    = 1'b0;
        ifa.m1_request = 1'b0;
        step("m1_idle", 0, 7'b0000000);

        // both held: round-robin alternation
        do_reset("reset_rr");
        ifa.m1_request = 1'b1;
        ifa.m2_request = 1'b1;
        step("rr_m1_c1", 0, G1);
        step("rr_m1_c2", 0, G1);
        step("rr_m1_c3", 0, G1);
        ifa.m1_done = 1'b1;
        step("rr_turn1", 0, 7'b0000000);
        ifa.m1_done = 1'b0;
        step("rr_idle1", 0, 7'b0000000);
        step("rr_m2_c1", 0, G2);
        step("rr_m2_c2", 0, G2);
        step("rr_m2_c3", 0, G2);
        ifa.m2_done = 1'b1;
        step("rr_turn2", 0, 7'b0000100);
        ifa.m2_done = 1'b0;
        step("rr_idle2", 0, 7'b0000100);
        step("rr_m1_again", 0, G1);
        ifa.m1_done    = 1'b1;
        ifa.m1_request = 1'b0;
        ifa.m2_request = 1'b0;
        step("rr_turn3", 0, 7'b0000000);
        ifa.m1_done = 1'b0;
        step("rr_idle3", 0, 7'b0000000);

        // m2 request pulse during m1 ownership is ignored
        ifa.m1_request = 1'b1;
        step("own_m1", 0, G1);
        ifa.m2_request = 1'b1;
        step("own_m2_pulse", 0, G1);
        ifa.m2_request = 1'b0;
        step("own_m1_keep", 0, G1);
        ifa.m1_done    = 1'b1;
        ifa.m1_request = 1'b0;
        step("own_turn", 0, 7'b0000000);
        ifa.m1_done = 1'b0;
        step("own_idle", 0, 7'b0000000);
        step("own_no_m2", 0, 7'b0000000);

        // asynchronous reset while m2 owns the bus
        ifa.m2_request = 1'b1;
        step("ar_m2", 0, G2);
        step("ar_m2_hold", 0, G2);
        reset = 1'b0;
        #2;
        chk("ar_async", vec_a, 7'b0000000);
        @(posedge clk);
        #1;
        chk("ar_held", vec_a, 7'b0000000);
        reset = 1'b1;
        ifa.m1_request = 1'b1;
        step("ar_m1_first", 0, G1);
        ifa.m1_done    = 1'b1;
        ifa.m1_request = 1'b0;
        ifa.m2_request = 1'b0;
        step("ar_turn", 0, 7'b0000000);
        ifa.m1_done = 1'b0;

        // TIMEOUT=4: forced release of m2, then m1 wins the re-arbitration
        ifb.m2_request = 1'b1;
        step("to_m2_c1", 1, G2);
        step("to_m2_c2", 1, G2);
        step("to_m2_c3", 1, G2);
        step("to_m2_c4", 1, G2);
        step("to_pulse", 1, 7'b0000111);
        ifb.m1_request = 1'b1;
        step("to_idle", 1, 7'b0000101);
        step("to_m1_rr", 1, 7'b1001001);
        step("to_m1_c2", 1, 7'b1001001);
        step("to_m1_c3", 1, 7'b1001001);
        step("to_m1_c4", 1, 7'b1001001);
        ifb.m1_done    = 1'b1;
        ifb.m1_request = 1'b0;
        ifb.m2_request = 1'b0;
        step("to_done_lim", 1, 7'b0000001);
        ifb.m1_done = 1'b0;
        step("to_done_idle", 1, 7'b0000001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
